// File: rtl/add64_issue_stage.sv
// Issue/capture stage around the combinational lookahead64 adder: registers operands,
// captures the sum and carry, and keeps a running accumulator. `ADD64_OVF_EN adds out_ovf.
module add64_issue_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
`ifdef ADD64_OVF_EN
    output logic             out_ovf,
`endif
    output logic [WIDTH-1:0] acc_q
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, OPER, HOLD} state_t;

    state_t state, state_nx;
    logic   accept;
    logic   upd_acc;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nx = OPER;
            end
            OPER: state_nx = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
                if (out_ready) state_nx = in_valid ? OPER : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operands stay put on the adder for the whole OPER cycle; the mode decision is
    // latched as a single "update accumulator" flag for the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_a <= '0;
            adder_b <= '0;
            upd_acc <= 1'b0;
        end else if (accept) begin
            case (in_mode)
                2'b01: begin
                    adder_a <= acc_q;
                    adder_b <= in_b;
                    upd_acc <= 1'b1;
                end
                2'b10: begin
                    adder_a <= in_a;
                    adder_b <= '0;
                    upd_acc <= 1'b1;
                end
                default: begin
                    adder_a <= in_a;
                    adder_b <= in_b;
                    upd_acc <= 1'b0;
                end
            endcase
        end
    end

    // Capture happens only on the OPER->HOLD edge, so results hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum   <= '0;
            out_carry <= 1'b0;
            acc_q     <= '0;
        end else if (state == OPER) begin
            out_sum   <= adder_sum;
            out_carry <= (adder_a[MSB] & adder_b[MSB]) |
                         ((adder_a[MSB] ^ adder_b[MSB]) & ~adder_sum[MSB]);
            if (upd_acc) acc_q <= adder_sum;
        end
    end

`ifdef ADD64_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 out_ovf <= 1'b0;
        else if (state == OPER)  out_ovf <= (adder_a[MSB] == adder_b[MSB]) &&
                                            (adder_sum[MSB] != adder_a[MSB]);
    end
`endif

endmodule
